// File: rtl/alu_pkg.sv
// Shared ALU definitions: controller state encoding, add/sub mode codes, slice width.
// Pure declarations, no logic, so there is no latency or backpressure.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;
   localparam int   NIB      = 4;

endpackage

// File: rtl/nibble_addsub.sv
// Combinational 4-bit ripple add/subtract slice built from full adders, with zero latency.
// There is no handshake, and mode inverts b while the caller supplies cin.
module nibble_addsub
   import alu_pkg::*;
(
   input  logic [NIB-1:0] a,
   input  logic [NIB-1:0] b,
   input  logic           mode,
   input  logic           cin,
   output logic [NIB-1:0] sum,
   output logic           cout
);

   logic [NIB-1:0] bx;
   logic [NIB:0]   c;

   assign c[0] = cin;

   for (genvar i = 0; i < NIB; i++) begin : g_fa
      assign bx[i]    = b[i] ^ mode;
      assign sum[i]   = a[i] ^ bx[i] ^ c[i];
      assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
   end

   assign cout = c[NIB];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Serial WIDTH-bit add/sub, one nibble per clock with LSB first; the result is valid NIBBLES cycles after accept.
// The result and flags are held in DONE until out_ready, and in_ready stays low until the FSM returns to IDLE.
module nibble_serial_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             busy
);

   localparam int NIBBLES = WIDTH / NIB;
   localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic             mode_q, mode_d, carry_q, carry_d;
   logic             cout_q, cout_d, ovf_q, ovf_d;

   logic [NIB-1:0]   slice_a, slice_b, slice_sum;
   logic             slice_cout;

   assign slice_a = a_q[idx_q*NIB +: NIB];
   assign slice_b = b_q[idx_q*NIB +: NIB];

   nibble_addsub u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .mode (mode_q),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      mode_d  = mode_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_RUN: begin
            res_d[idx_q*NIB +: NIB] = slice_sum;
            carry_d                 = slice_cout;
            if (idx_q == IDX_LAST) begin
               // The MSB nibble sum bit is the result MSB, so it can be used before it is registered.
               cout_d  = slice_cout;
               ovf_d   = (a_q[WIDTH-1] ^ slice_sum[NIB-1]) &
                         ((b_q[WIDTH-1] ^ mode_q) ^ slice_sum[NIB-1]);
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               mode_d  = mode;
               idx_d   = '0;
               res_d   = '0;
               carry_d = (mode == MODE_SUB);
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               state_d = ST_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         mode_q  <= MODE_ADD;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         mode_q  <= mode_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Handshake outputs decode the state flop directly, and the unused encoding 2'd3 reads as idle.
   assign in_ready  = (state_q != ST_RUN) && (state_q != ST_DONE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign result    = res_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: a scoreboard queue is filled from an arithmetic reference model at accept time.
// A negedge monitor checks latency, held outputs and the result of each out_valid handshake.
module tb_nibble_serial_addsub;

   localparam int W     = 16;
   localparam int NIB_N = W / 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, mode, out_valid, out_ready;
   logic         carry_out, overflow, busy;
   logic [W-1:0] a, b, result;

   typedef struct {
      logic [W-1:0] res;
      logic         c;
      logic         v;
      int           acc;
   } exp_t;

   exp_t         sb_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   int           last_acc = 0;
   bit           hold     = 0;
   bit           rand_done;
   logic [W-1:0] h_res;
   logic         h_c, h_v;

   nibble_serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
      exp_t   e;
      longint ux, uy, sx, sy, r, sr;
      ux = longint'(x);
      uy = longint'(y);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (m) begin
         r   = ux - uy;
         sr  = sx - sy;
         e.c = (ux >= uy);
      end else begin
         r   = ux + uy;
         sr  = sx + sy;
         e.c = (r >= (longint'(1) << W));
      end
      e.res = r[W-1:0];
      e.v   = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
      e.acc = 0;
      return e;
   endfunction

   task automatic chk(input string nm, input longint act, input longint req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s", nm);
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
      exp_t e;
      int   guard;
      @(posedge clk); #1;
      a        = x;
      b        = y;
      mode     = m;
      in_valid = 1'b1;
      guard    = 0;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         guard++;
         if (guard > 200) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
         end
      end
      e        = model(x, y, m);
      e.acc    = cyc + 1;
      last_acc = cyc + 1;
      sb_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      mode     = 1'($urandom);
   endtask

   task automatic drain();
      int guard = 0;
      while (sb_q.size() != 0) begin
         @(negedge clk);
         guard++;
         if (guard > 200) begin
            fail_now("drain_timeout");
            sb_q.delete();
         end
      end
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         hold = 0;
      end else if (out_valid === 1'b1) begin
         chk("in_ready_in_done", in_ready, 0);
         chk("busy_in_done", busy, 1);
         if (!hold) begin
            if (sb_q.size() == 0) fail_now("unexpected_out_valid");
            else chk("latency", cyc - sb_q[0].acc, NIB_N);
         end else begin
            chk("hold_result", result, h_res);
            chk("hold_carry", carry_out, h_c);
            chk("hold_ovf", overflow, h_v);
         end
         if (out_ready === 1'b1 && sb_q.size() != 0) begin
            chk("result", result, sb_q[0].res);
            chk("carry_out", carry_out, sb_q[0].c);
            chk("overflow", overflow, sb_q[0].v);
            void'(sb_q.pop_front());
         end
         hold  = (out_ready !== 1'b1);
         h_res = result;
         h_c   = carry_out;
         h_v   = overflow;
      end else begin
         hold = 0;
      end
   end

   logic [W-1:0] dir_a [5] = '{16'h1234, 16'h0005, 16'h7FFF, 16'hFFFF, 16'h8000};
   logic [W-1:0] dir_b [5] = '{16'h0FFF, 16'h0007, 16'h0001, 16'h0001, 16'h0001};
   logic         dir_m [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      int guard;
      int acc1;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      mode      = 1'b0;
      out_ready = 1'b1;
      rand_done = 0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 0);
      chk("rst_carry", carry_out, 0);
      chk("rst_ovf", overflow, 0);

      for (int i = 0; i < 5; i++) begin
         send(dir_a[i], dir_b[i], dir_m[i]);
         drain();
      end

      // Backpressure: hold DONE for 10 cycles while the inputs are disturbed.
      out_ready = 1'b0;
      send(16'h1357, 16'h2468, 1'b0);
      guard = 0;
      while (out_valid !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) fail_now("bp_out_valid_timeout");
      repeat (10) begin
         @(posedge clk); #1;
         in_valid = 1'($urandom);
         a        = W'($urandom);
         b        = W'($urandom);
         mode     = 1'($urandom);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_idle_in_ready", in_ready, 1);
      chk("bp_idle_out_valid", out_valid, 0);
      chk("bp_queue_empty", sb_q.size(), 0);

      // Reset after two RUN cycles discards the operation.
      send(16'hABCD, 16'h1111, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      sb_q.delete();
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_result", result, 0);
      send(16'h0001, 16'h0001, 1'b0);
      drain();

      // Back-to-back with out_ready tied high.
      send(16'h4000, 16'h4000, 1'b0);
      acc1 = last_acc;
      send(16'h0000, 16'h0001, 1'b1);
      chk("b2b_spacing", last_acc - acc1, NIB_N + 2);
      drain();

      // Random operations with random consumer backpressure.
      fork
         begin
            repeat (40) send(W'($urandom), W'($urandom), 1'($urandom));
            drain();
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
